// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe skid-buffer pipeline.
package reg_pipe_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned STAGES_DEF = 4;
  localparam int unsigned STAGES_MAX = 16;

  // Width of the occupancy counter: must represent 0 .. 2*stages.
  function automatic int unsigned count_w(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One two-entry skid stage: main register drives downstream, skid catches a word
// accepted while downstream stalls. Ready is registered from a look-ahead computed upstream.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int unsigned            WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             ready_next,
  output logic             skid_next_c
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             main_valid_n;
  logic             skid_valid_n;
  logic [WIDTH-1:0] main_data_n;
  logic [WIDTH-1:0] skid_data_n;
  logic             in_fire;
  logic             main_take;

  // Skid always drains into main before main is refilled from upstream.
  always_comb begin
    in_fire      = in_valid & in_ready & ~flush;
    main_take    = ~out_valid | out_ready;
    main_valid_n = out_valid;
    main_data_n  = out_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (main_take) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        skid_valid_n = in_fire;
        if (in_fire) skid_data_n = in_data;
      end else begin
        main_valid_n = in_fire;
        if (in_fire) main_data_n = in_data;
      end
    end else if (in_fire) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end
    skid_next_c = skid_valid_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      out_data   <= RESET_VAL;
      skid_data  <= RESET_VAL;
    end else begin
      out_valid  <= main_valid_n;
      skid_valid <= skid_valid_n;
      in_ready   <= ready_next;
      out_data   <= main_data_n;
      skid_data  <= skid_data_n;
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Chain of STAGES skid stages with registered ready on every stage and a single
// up/down occupancy counter.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = WIDTH_DEF,
  parameter int unsigned      STAGES    = STAGES_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [count_w(STAGES)-1:0]    count
);

  localparam int unsigned CW = count_w(STAGES);

  if (WIDTH < 1 || STAGES < 1 || STAGES > STAGES_MAX) begin : g_param_err
    $error("reg_pipe: illegal WIDTH=%0d or STAGES=%0d", WIDTH, STAGES);
  end

  logic [STAGES:0]   v;
  logic [STAGES:0]   r;
  logic [STAGES:0]   rn;
  logic [STAGES-1:0] sn;
  logic [WIDTH-1:0]  d [STAGES+1];
  logic              in_fire;
  logic              out_fire;

  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign r[STAGES] = out_ready;
  assign in_ready  = r[0];
  assign out_valid = v[STAGES];
  assign out_data  = d[STAGES];

  // A stage may accept next cycle if its skid will be empty, or if the stage
  // below is guaranteed to take its main word next cycle.
  always_comb begin
    rn = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      rn[i] = ~sn[i] | rn[i+1];
    end
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
    reg_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (v[g]),
      .in_ready    (r[g]),
      .in_data     (d[g]),
      .out_valid   (v[g+1]),
      .out_ready   (r[g+1]),
      .out_data    (d[g+1]),
      .ready_next  (rn[g]),
      .skid_next_c (sn[g])
    );
  end

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_fire & ~out_fire) begin
      count <= count + CW'(1);
    end else if (out_fire & ~in_fire) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// Randomized and directed bench for reg_pipe (8x4 and 1x1 instances) against a queue model.
module tb_reg_pipe;

  localparam int STAGES = 4;
  localparam int FULL   = 8;
  localparam int C_FULL = 2;

  logic       clk, rst, flush;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [3:0] count;
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_in_data, c_out_data;
  logic [1:0] c_count;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  logic [7:0] q[$];
  logic       cq[$];

  reg_pipe #(.WIDTH(8), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  reg_pipe #(.WIDTH(1), .STAGES(1)) dut_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of traffic on both instances; model updated from observed handshakes.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic fi, fo, stall, full, cfi, cfo, cstall, cfull, cpd;
    logic [7:0] pd;
    in_valid = iv;  in_data = id;  out_ready = ordy;  flush = fl;
    c_in_valid = iv;  c_in_data = id[0];  c_out_ready = ordy;
    fi = iv & in_ready & ~fl;        fo = out_valid & ordy;
    stall = out_valid & ~ordy;       pd = out_data;   full = (q.size() == FULL);
    cfi = iv & c_in_ready & ~fl;     cfo = c_out_valid & ordy;
    cstall = c_out_valid & ~ordy;    cpd = c_out_data; cfull = (cq.size() == C_FULL);
    if (fo) begin
      if (q.size() == 0) check("spurious_out", 32'(out_valid), 0);
      else check("order", 32'(out_data), 32'(q[0]));
    end
    if (cfo) begin
      if (cq.size() == 0) check("c_spurious_out", 32'(c_out_valid), 0);
      else check("c_order", 32'(c_out_data), 32'(cq[0]));
    end
    @(posedge clk);
    #1;
    if (fo && q.size() != 0) void'(q.pop_front());
    if (cfo && cq.size() != 0) void'(cq.pop_front());
    if (fl) begin
      q.delete();
      cq.delete();
    end else begin
      if (fi) begin q.push_back(id); n_acc++; end
      if (cfi) cq.push_back(id[0]);
    end
    check("count", 32'(count), 32'(q.size()));
    check("c_count", 32'(c_count), 32'(cq.size()));
    if (q.size() > FULL) check("overflow", 32'(q.size()), FULL);
    if (q.size() == 0) check("empty_valid", 32'(out_valid), 0);
    if (cq.size() == 0) check("c_empty_valid", 32'(c_out_valid), 0);
    if (q.size() == FULL) check("full_ready", 32'(in_ready), 0);
    if (cq.size() == C_FULL) check("c_full_ready", 32'(c_in_ready), 0);
    if (stall && !fl) begin
      check("hold_valid", 32'(out_valid), 1);
      check("hold_data", 32'(out_data), 32'(pd));
    end
    if (cstall && !fl) begin
      check("c_hold_valid", 32'(c_out_valid), 1);
      check("c_hold_data", 32'(c_out_data), 32'(cpd));
    end
    if (full && fo && !fl) check("full_release", 32'(in_ready), 1);
    if (cfull && cfo && !fl) check("c_full_release", 32'(c_in_ready), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (q.size() != 0 || cq.size() != 0); i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", 32'(q.size()), 0);
    check("c_drain_empty", 32'(cq.size()), 0);
  endtask

  task automatic reset_checks();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_count", 32'(count), 0);
    check("c_rst_out_valid", 32'(c_out_valid), 0);
    check("c_rst_in_ready", 32'(c_in_ready), 0);
    check("c_rst_count", 32'(c_count), 0);
  endtask

  task automatic assert_reset();
    in_valid = 1'b0;  c_in_valid = 1'b0;  out_ready = 1'b0;  c_out_ready = 1'b0;  flush = 1'b0;
    #2 rst = 1'b0;
    #1 reset_checks();
    q.delete();
    cq.delete();
  endtask

  // First edge after release must not transfer even with in_valid high.
  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;  in_data = 8'h5A;  c_in_valid = 1'b1;  c_in_data = 1'b1;
    @(posedge clk);
    #1;
    check("no_xfer_first_edge", 32'(count), 0);
    check("c_no_xfer_first_edge", 32'(c_count), 0);
    check("ready_after_rst", 32'(in_ready), 1);
    check("c_ready_after_rst", 32'(c_in_ready), 1);
    in_valid = 1'b0;  c_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;  flush = 1'b0;
    in_valid = 1'b0;  in_data = 8'h00;  out_ready = 1'b0;
    c_in_valid = 1'b0;  c_in_data = 1'b0;  c_out_ready = 1'b0;
    #1 rst = 1'b0;
    #2 reset_checks();
    release_reset();

    // Latency: 8x4 shows the word STAGES-1 edges after acceptance, 1x1 at once.
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check("c_lat_valid", 32'(c_out_valid), 1);
    check("c_lat_data", 32'(c_out_data), 1);
    for (int k = 0; k < STAGES; k++) begin
      if (k > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
      check("lat_valid", 32'(out_valid), 32'(k == STAGES - 1));
      if (k == 0) check("lat_count", 32'(count), 1);
    end
    check("lat_data", 32'(out_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_count_back", 32'(count), 0);
    drain();

    // Throughput: one word per cycle, no bubbles.
    for (int j = 0; j < 20; j++) begin
      step(1'b1, 8'(j + 16), 1'b1, 1'b0);
      check("tput_ready", 32'(in_ready), 1);
      check("c_tput_valid", 32'(c_out_valid), 1);
      if (j >= STAGES - 1) check("tput_valid", 32'(out_valid), 1);
    end
    drain();

    // Fill to capacity while stalled, then drain in order one per cycle.
    for (int j = 1; j <= 8; j++) step(1'b1, 8'(j), 1'b0, 1'b0);
    check("full_count8", 32'(count), 8);
    check("full_in_ready0", 32'(in_ready), 0);
    check("c_full_count2", 32'(c_count), 2);
    for (int j = 1; j <= 8; j++) begin
      check("drain_valid", 32'(out_valid), 1);
      check("drain_data", 32'(out_data), 32'(j));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_count0", 32'(count), 0);

    // Flush with 5 stored words and a simultaneous input word.
    for (int j = 0; j < 5; j++) step(1'b1, 8'(8'h20 + j), 1'b0, 1'b0);
    check("pre_flush_count", 32'(count), 5);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(out_valid), 0);
    check("c_flush_count", 32'(c_count), 0);
    for (int j = 0; j < 3; j++) step(1'b1, 8'(8'h30 + j), 1'b1, 1'b0);
    for (int j = 0; j < 12; j++) begin
      if (out_valid) check("no_77", 32'(out_data == 8'h77), 0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    drain();

    // Asynchronous reset mid-stream.
    for (int j = 0; j < 3; j++) step(1'b1, 8'(8'h40 + j), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 3);
    assert_reset();
    release_reset();
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 16 && !out_valid; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("first_after_rst_valid", 32'(out_valid), 1);
    check("first_after_rst_data", 32'(out_data), 32'h3C);
    drain();

    // Random streaming, 1000 accepted words.
    n_acc = 0;
    for (int cyc = 0; cyc < 20000 && n_acc < 1000; cyc++)
      step(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), 1'b0);
    check("stream_words", 32'(n_acc), 1000);
    drain();

    // Random traffic with occasional flush.
    for (int cyc = 0; cyc < 300; cyc++)
      step(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), ($urandom % 16) == 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 The block SHALL be parameterised as follows, one per line (name, default, meaning):
- WIDTH, 8: data width in bits, legal range 1 or more.
- STAGES, 4: number of register stages, legal range 1 to 16.
- RESET_VAL, '0: value loaded into every data register on reset.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports are listed one per line (name, direction, width, meaning):
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous clear of all stored words.
- in_valid, input, 1: upstream word present.
- in_ready, output, 1: block can accept a word; registered.
- in_data, input, WIDTH: upstream word.
- out_valid, output, 1: output word present; registered.
- out_ready, input, 1: downstream accepts the word.
- out_data, output, WIDTH: output word; registered.
- count, output, $clog2(2*STAGES+1): number of words currently stored.
REQ-003 An illegal WIDTH or STAGES SHALL cause an elaboration-time error.

Function
REQ-004 An input transfer SHALL occur on a clk rising edge with in_valid=1, in_ready=1 and flush=0.
REQ-005 An output transfer SHALL occur on a clk rising edge with out_valid=1 and out_ready=1.
REQ-006 Each stage SHALL be a two-entry skid register (main plus skid), so total capacity is 2*STAGES words.
REQ-007 Every stage's ready SHALL be a register output, with no combinational path from out_ready to in_ready.
REQ-008 Words SHALL leave in acceptance order, with no loss and no duplication.
REQ-009 With out_ready held at 1 and the block empty, a word accepted at edge N SHALL be presented with out_valid=1 after edge N+STAGES-1.
REQ-010 With out_ready held at 1, sustained throughput SHALL be one word per cycle, with no bubbles inserted.
REQ-011 Once out_valid=1, out_valid and out_data SHALL hold unchanged until the output transfer occurs, regardless of new input.
REQ-012 Upstream SHALL hold in_data stable while in_valid=1 and in_ready=0; the block stores no word in that cycle.
REQ-013 count SHALL change by the following rules:
- Input transfer only: +1.
- Output transfer only: -1.
- Both in the same cycle: unchanged.
- count never exceeds 2*STAGES and never drops below 0.
REQ-014 Full condition (count=2*STAGES): in_ready SHALL be 0. An output transfer while full SHALL raise in_ready on the following edge.
REQ-015 Empty condition (count=0): out_valid SHALL be 0 and out_data SHALL hold its last value.
REQ-016 Flush, when asserted at an edge, SHALL:
- Clear all valid bits and count to 0 at that edge.
- Discard any simultaneous input word.
- Still complete a simultaneous output transfer of the word already presented.
REQ-017 Flush SHALL take priority over all other events.
REQ-018 Data registers SHALL not be cleared by flush; only the valid state is cleared.
REQ-019 A stage's skid entry SHALL fill only when its downstream stalls while it is accepting. The skid entry SHALL drain before the main register is refilled from upstream.

Reset
REQ-020 When rst=0, asynchronously and independent of clk, the block SHALL set:
- All valid bits to 0.
- count to 0.
- out_valid to 0.
- in_ready to 0.
- out_data and all data registers to RESET_VAL.
REQ-021 After rst returns to 1, in_ready SHALL be 1 from the first rising edge onward. No transfer SHALL occur on that first edge.
REQ-022 Reset asserted mid-operation SHALL discard all stored words. No partial word SHALL appear at the output after reset is released.

Structure
REQ-023 Package reg_pipe_pkg SHALL hold:
- Default constants for WIDTH, STAGES and the STAGES maximum (16).
- A count-width function, clog2(2*STAGES+1).
REQ-024 Sub-module reg_pipe_stage SHALL implement one skid stage: WIDTH parameter, valid/ready on each side, flush input. reg_pipe SHALL instantiate STAGES copies of it in a generate loop.
REQ-025 count SHALL be maintained by one up/down counter in reg_pipe, not summed from the stages.

Verification
REQ-026 Latency: STAGES=4, WIDTH=8, out_ready=1; send 0xA5 at edge 10 -> out_valid=1 with out_data=0xA5 after edge 13; count goes 1 then returns to 0 after the output transfer.
REQ-027 Full/stall: out_ready=0; send 0x01..0x08 back-to-back -> in_ready=0 after the eighth word, count=8. Then out_ready=1 -> outputs 0x01..0x08 in order, one per cycle.
REQ-028 Streaming: 1000 random words with random in_valid/out_ready (50% each) -> scoreboard order match, zero loss, count always within 0..8, out_data stable while stalled.
REQ-029 Flush: with count=5, assert flush for one cycle while in_valid=1 with in_data=0x77 -> count=0, out_valid=0 next cycle, 0x77 never appears at the output.
REQ-030 Reset mid-stream: rst=0 asynchronously with count=3 -> immediately out_valid=0, in_ready=0, out_data=RESET_VAL. After release, in_ready=1 after the first edge and the first output word is the first word sent after reset.
REQ-031 Corner parameters: STAGES=1, WIDTH=1 -> capacity 2, latency 0 cycles after the accepting edge, REQ-028 traffic passes.
